// File: rtl/project_types.sv
// project_types: shared types and defaults for the MEM-stage data RAM.
//   chip_status_t / CHIP_ENABLE : request strobe encoding reused across blocks
//   ram_state_t                 : data RAM controller states
//   DATA_RAM_DEPTH              : default number of words
//   DATA_RAM_READ_LATENCY       : default read latency in cycles
package project_types;

    typedef enum logic {
        CHIP_DISABLE = 1'b0,
        CHIP_ENABLE  = 1'b1
    } chip_status_t;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } ram_state_t;

    localparam int DATA_RAM_DEPTH        = 131072;
    localparam int DATA_RAM_READ_LATENCY = 1;

endpackage

// File: rtl/data_ram_bank.sv
// data_ram_bank: one 8-bit byte lane of the data RAM.
// Synchronous write enable, synchronous registered read.
//   clk   : clock
//   we    : write wdata into mem[idx] at the rising edge
//   re    : capture mem[idx] into rdata at the rising edge
//   idx   : word index
//   wdata : write byte
//   rdata : read byte, valid the cycle after re
module data_ram_bank #(
    parameter int IDX_W = 17,
    parameter int DEPTH = 131072
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_ram_sync.sv
// data_ram_sync: synchronous byte-lane data RAM for the MEM stage.
// One request per cycle under a ready handshake; reads return through a
// READ_LATENCY-deep non-stallable pipeline with a one-cycle valid_o pulse.
// Optional feature macro: DATA_RAM_CLEAR_EN compiles in a post-reset sweep
// that zeroes every word before the first request is accepted.
//
//   clk     : clock
//   rst     : asynchronous active-high reset
//   ce      : request strobe (request present when CHIP_ENABLE)
//   we      : 1 = write, 0 = read
//   sel     : byte-lane write enables
//   addr    : byte address (word index taken above the byte offset)
//   data_i  : write data
//   ready   : request can be accepted this cycle
//   data_o  : read data, '0 when valid_o is low
//   valid_o : read result strobe
//
// state   | meaning
// S_CLEAR | sweeping index 0..DEPTH_WORDS-1 writing zero, ready = 0
// S_RUN   | normal operation, ready = 1
module data_ram_sync
    import project_types::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int DEPTH_WORDS  = DATA_RAM_DEPTH,
    parameter int READ_LATENCY = DATA_RAM_READ_LATENCY
) (
    input  logic                clk,
    input  logic                rst,
    input  chip_status_t        ce,
    input  logic                we,
    input  logic [DATA_W/8-1:0] sel,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_i,
    output logic                ready,
    output logic [DATA_W-1:0]   data_o,
    output logic                valid_o
);

    localparam int LANES = DATA_W / 8;
    localparam int OFS_W = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    ram_state_t        state;
    logic              accept;
    logic              wr_acc;
    logic              rd_acc;
    logic              clearing;
    logic [IDX_W-1:0]  addr_idx;
    logic [IDX_W-1:0]  bank_idx;
    logic [DATA_W-1:0] bank_rdata;
    logic [DATA_W-1:0] rd_last;
    logic [READ_LATENCY-1:0] vpipe;

    // Byte-offset bits and bits above the index are deliberately ignored.
    logic addr_unused;
    assign addr_unused = ^addr;

    assign addr_idx = addr[OFS_W +: IDX_W];
    assign accept   = (ce == CHIP_ENABLE) && ready;
    assign wr_acc   = accept && we;
    assign rd_acc   = accept && !we;

`ifdef DATA_RAM_CLEAR_EN
    logic [IDX_W-1:0] clr_cnt;

    assign clearing = (state == S_CLEAR);
    assign bank_idx = clearing ? clr_cnt : addr_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    // Leave on the edge that writes the last word so ready
                    // is high the following cycle.
                    if (clr_cnt == {IDX_W{1'b1}}) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= S_CLEAR;
                    ready <= 1'b0;
                end
            endcase
        end
    end
`else
    assign clearing = 1'b0;
    assign bank_idx = addr_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
            ready <= 1'b0;
        end else begin
            case (state)
                S_RUN:   ready <= 1'b1;
                default: state <= S_RUN;
            endcase
        end
    end
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic       lane_we;
        logic [7:0] lane_wdata;

        assign lane_we    = clearing || (wr_acc && sel[i]);
        assign lane_wdata = clearing ? 8'h00 : data_i[8*i +: 8];

        data_ram_bank #(
            .IDX_W (IDX_W),
            .DEPTH (DEPTH_WORDS)
        ) u_bank (
            .clk   (clk),
            .we    (lane_we),
            .re    (rd_acc),
            .idx   (bank_idx),
            .wdata (lane_wdata),
            .rdata (bank_rdata[8*i +: 8])
        );
    end

    // The bank read register is the first latency stage; further stages
    // only delay the result. Valid is tracked separately so a reset drops
    // any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign rd_last = bank_rdata;
    end else begin : g_latn
        logic [DATA_W-1:0] dpipe [READ_LATENCY-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < READ_LATENCY - 1; i++) begin
                    dpipe[i] <= '0;
                end
            end else begin
                dpipe[0] <= bank_rdata;
                for (int i = 1; i < READ_LATENCY - 1; i++) begin
                    dpipe[i] <= dpipe[i-1];
                end
            end
        end

        assign rd_last = dpipe[READ_LATENCY-2];
    end

    assign valid_o = vpipe[READ_LATENCY-1];
    assign data_o  = valid_o ? rd_last : '0;

endmodule

// File: tb/tb_data_ram_sync.sv
// Scoreboard bench for data_ram_sync. Three instances share one clock:
//   dut0 DEPTH 16 latency 1, dut1 DEPTH 16 latency 3, dut2 DEPTH 16 latency 2.
// Expectations depend on whether DATA_RAM_CLEAR_EN is defined for the build.
module tb_data_ram_sync;
    import project_types::*;

    typedef struct {
        int          dut;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_s   [3];
    chip_status_t ce_s    [3];
    logic         we_s    [3];
    logic [3:0]   sel_s   [3];
    logic [31:0]  addr_s  [3];
    logic [31:0]  din_s   [3];
    logic         ready_s [3];
    logic [31:0]  dout_s  [3];
    logic         valid_s [3];

    exp_t sb[$];
    int   cyc   = 0;
    int   ncmp  = 0;
    int   nfail = 0;

`ifdef DATA_RAM_CLEAR_EN
    localparam bit CLEAR_ON = 1'b1;
`else
    localparam bit CLEAR_ON = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_ram_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(16), .READ_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst_s[0]), .ce(ce_s[0]), .we(we_s[0]), .sel(sel_s[0]),
        .addr(addr_s[0]), .data_i(din_s[0]), .ready(ready_s[0]),
        .data_o(dout_s[0]), .valid_o(valid_s[0]));

    data_ram_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(16), .READ_LATENCY(3)) dut1 (
        .clk(clk), .rst(rst_s[1]), .ce(ce_s[1]), .we(we_s[1]), .sel(sel_s[1]),
        .addr(addr_s[1]), .data_i(din_s[1]), .ready(ready_s[1]),
        .data_o(dout_s[1]), .valid_o(valid_s[1]));

    data_ram_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(16), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst_s[2]), .ce(ce_s[2]), .we(we_s[2]), .sel(sel_s[2]),
        .addr(addr_s[2]), .data_i(din_s[2]), .ready(ready_s[2]),
        .data_o(dout_s[2]), .valid_o(valid_s[2]));

    function automatic int rl(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    // Monitor: every valid_o pulse must match the oldest expectation in
    // DUT, data and cycle; data_o must be zero whenever valid_o is low.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (valid_s[d]) begin
                ncmp++;
                if (sb.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_valid dut%0d cyc=%0d data=%h, required no valid", d, cyc, dout_s[d]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.dut != d || e.data !== dout_s[d] || e.cyc != cyc) begin
                        nfail++;
                        $display("FAIL read_data dut%0d got data=%h cyc=%0d, required dut%0d data=%h cyc=%0d",
                                 d, dout_s[d], cyc, e.dut, e.data, e.cyc);
                    end
                end
            end else if (!rst_s[d]) begin
                ncmp++;
                if (dout_s[d] !== 32'h0) begin
                    nfail++;
                    $display("FAIL idle_data dut%0d cyc=%0d got %h, required 00000000", d, cyc, dout_s[d]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input int d);
        int n = 0;
        while (!ready_s[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_s[d]) begin
            ncmp++;
            nfail++;
            $display("FAIL ready_timeout dut%0d got 0, required 1 within 100 cycles", d);
        end
    endtask

    // Drives one request for one cycle (leaves it on the bus for chaining).
    task automatic issue(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] dat, input logic [3:0] s, input logic [31:0] e);
        wait_ready(d);
        ce_s[d]   = CHIP_ENABLE;
        we_s[d]   = w;
        addr_s[d] = a;
        din_s[d]  = dat;
        sel_s[d]  = s;
        if (!w) begin
            exp_t x;
            x.dut  = d;
            x.data = e;
            x.cyc  = cyc + rl(d);
            sb.push_back(x);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int d);
        ce_s[d] = CHIP_DISABLE;
        we_s[d] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ncmp++;
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL drain got %0d pending reads, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Checks ready over the cycles following a reset release.
    task automatic sweep_ready(input int d, input string nm);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk(nm, {31'b0, ready_s[d]}, {31'b0, (CLEAR_ON ? (k == 16) : 1'b1)});
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_s[d] = 1'b1;
            idle(d);
            sel_s[d]  = 4'h0;
            addr_s[d] = 32'h0;
            din_s[d]  = 32'h0;
        end
        // A write held on dut0 through reset and the clear window must be ignored.
        ce_s[0] = CHIP_ENABLE; we_s[0] = 1'b1; addr_s[0] = 32'h8;
        din_s[0] = 32'hDEADBEEF; sel_s[0] = 4'hF;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) chk("reset_ready", {31'b0, ready_s[d]}, 32'h0);
        for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;

        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++)
                chk("clear_ready", {31'b0, ready_s[d]}, {31'b0, (CLEAR_ON ? (k == 16) : 1'b1)});
            if (ready_s[0]) idle(0);
        end
        idle(0);

        // Every word reads zero after the sweep, including the ignored write target.
        if (CLEAR_ON) begin
            for (int i = 0; i < 16; i++) issue(0, 1'b0, 32'(i * 4), 32'h0, 4'hF, 32'h0);
            idle(0);
            drain();
        end

        // Byte lanes, write-then-read next cycle.
        issue(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b1111, 32'h0);
        issue(0, 1'b1, 32'h40, 32'h11223344, 4'b0101, 32'h0);
        issue(0, 1'b0, 32'h40, 32'h0,        4'b0000, 32'hAA22CC44);
        idle(0);
        drain();

        // Aliasing above the index and ignored byte-offset bits.
        issue(0, 1'b1, 32'h0,  32'h00000005, 4'hF, 32'h0);
        issue(0, 1'b0, 32'h40, 32'h0,        4'hF, 32'h00000005);
        issue(0, 1'b0, 32'h43, 32'h0,        4'h0, 32'h00000005);
        idle(0);
        drain();

        // sel == 0 no-op, top index, single-lane write.
        issue(0, 1'b1, 32'h4,  32'h01234567, 4'hF,    32'h0);
        issue(0, 1'b1, 32'h4,  32'hFFFFFFFF, 4'h0,    32'h0);
        issue(0, 1'b1, 32'h3C, 32'hFFFFFFFF, 4'hF,    32'h0);
        issue(0, 1'b1, 32'h3C, 32'h00000000, 4'b1000, 32'h0);
        issue(0, 1'b0, 32'h4,  32'h0, 4'h0, 32'h01234567);
        issue(0, 1'b0, 32'h3C, 32'h0, 4'h0, 32'h00FFFFFF);
        issue(0, 1'b0, 32'h7C, 32'h0, 4'h0, 32'h00FFFFFF);
        issue(0, 1'b0, 32'h0010003C, 32'h0, 4'h0, 32'h00FFFFFF);
        idle(0);
        drain();

        // Request held during reset is ignored.
        issue(0, 1'b1, 32'h8, 32'h00000000, 4'hF, 32'h0);
        idle(0);
        rst_s[0] = 1'b1;
        ce_s[0] = CHIP_ENABLE; we_s[0] = 1'b1; addr_s[0] = 32'h8;
        din_s[0] = 32'hDEADBEEF; sel_s[0] = 4'hF;
        repeat (3) @(negedge clk);
        idle(0);
        rst_s[0] = 1'b0;
        issue(0, 1'b0, 32'h8, 32'h0, 4'h0, 32'h00000000);
        idle(0);
        drain();

        // Latency 3: four back-to-back reads, then a gapped pair.
        issue(1, 1'b1, 32'h4,  32'h11111111, 4'hF, 32'h0);
        issue(1, 1'b1, 32'h8,  32'h22222222, 4'hF, 32'h0);
        issue(1, 1'b1, 32'hC,  32'h33333333, 4'hF, 32'h0);
        issue(1, 1'b1, 32'h10, 32'h44444444, 4'hF, 32'h0);
        issue(1, 1'b0, 32'h4,  32'h0, 4'h0, 32'h11111111);
        issue(1, 1'b0, 32'h8,  32'h0, 4'h0, 32'h22222222);
        issue(1, 1'b0, 32'hC,  32'h0, 4'h0, 32'h33333333);
        issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h44444444);
        idle(1);
        @(negedge clk);
        issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h44444444);
        idle(1);
        @(negedge clk);
        issue(1, 1'b0, 32'h4,  32'h0, 4'h0, 32'h11111111);
        idle(1);
        drain();

        // Latency 2: reset one cycle after a read is accepted drops it.
        issue(2, 1'b1, 32'h4, 32'h00000077, 4'hF, 32'h0);
        wait_ready(2);
        ce_s[2] = CHIP_ENABLE; we_s[2] = 1'b0; addr_s[2] = 32'h4;
        @(negedge clk);
        idle(2);
        rst_s[2] = 1'b1;
        #1;
        chk("midread_rst_ready", {31'b0, ready_s[2]}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_s[2] = 1'b0;
        sweep_ready(2, "midread_sweep_ready");
        issue(2, 1'b0, 32'h4, 32'h0, 4'h0, CLEAR_ON ? 32'h0 : 32'h00000077);
        idle(2);
        drain();

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
